// File: rtl/tile_flusher.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tile_flusher
//
// Purpose:
//   Drains one finished TILE_W x TILE_H tile from the tile BRAM after the
//   painter has finished with it. Words are read in raster order and each
//   word is streamed to the frame-buffer writer as an (address, colour)
//   beat over a valid/ready handshake. A BRAM word is {colour, depth}. A
//   depth of 16'hFFFF marks a wiped or untouched pixel, and such a pixel
//   is emitted as BG_COLOR.
//
// Ports:
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   start                one-cycle flush request, sampled only when idle
//   x_offset, y_offset   screen position of the tile's top-left pixel,
//                        latched when start is accepted
//   tile_bram_read_addr  registered BRAM read address (ty*TILE_W + tx)
//   tile_bram_read_data  BRAM read data, two cycles behind the address
//   pix_valid/pix_ready  output handshake
//   pix_addr             frame-buffer pixel address
//                        (y_offset+ty)*SCREEN_W + x_offset + tx
//   pix_color            pixel colour, or BG_COLOR for empty pixels
//   pix_last             marks the beat of the bottom-right pixel
//   busy                 high from start acceptance until done
//   done                 one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module tile_flusher #(
    parameter int          TILE_W     = 80,
    parameter int          TILE_H     = 10,
    parameter int          SCREEN_W   = 1280,
    parameter logic [15:0] BG_COLOR   = 16'h0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] x_offset,
    input  logic [9:0]  y_offset,
    output logic [9:0]  tile_bram_read_addr,
    input  logic [31:0] tile_bram_read_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [19:0] pix_addr,
    output logic [15:0] pix_color,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    localparam int TXW  = $clog2(TILE_W);
    localparam int TYW  = $clog2(TILE_H);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] color;
        logic        last;
    } beat_t;

    // One bit wider than the FIFO count so that count + in-flight cannot wrap.
    typedef logic [CNTW:0] used_t;

    // Control state
    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [10:0]     xOff_q;
    logic [9:0]      yOff_q;

    // Read-side raster position and registered BRAM address
    logic [TXW-1:0]  tx_q;
    logic [TYW-1:0]  ty_q;
    logic [9:0]      rdAddr_q;

    // In-flight tracking. Stage 1 lines up with valid BRAM read data.
    logic [1:0]      vld_q;
    logic [TXW-1:0]  txPipe0_q;
    logic [TXW-1:0]  txPipe1_q;
    logic [TYW-1:0]  tyPipe0_q;
    logic [TYW-1:0]  tyPipe1_q;

    // Output FIFO
    beat_t           fifoMem_q [FIFO_DEPTH];
    logic [PTRW-1:0] wrPtr_q;
    logic [PTRW-1:0] rdPtr_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    // Combinational helpers
    used_t           creditUsed;
    logic            issue;
    logic            lastIssue;
    logic            push;
    logic            pop;
    logic [19:0]     pushRow;
    logic [19:0]     pushAddr;
    logic [15:0]     pushColor;
    logic            pushLast;
    beat_t           pushBeat;
    beat_t           headBeat;

    // Credit rule: a read may be issued only if its result is guaranteed a
    // FIFO slot. Slots are counted as words already buffered plus words
    // still travelling through the BRAM pipeline. The beat for each word
    // is built here, before the FIFO, so that the FIFO head can drive the
    // outputs directly.
    always_comb begin
        creditUsed = used_t'(count_q) + used_t'(vld_q[0]) + used_t'(vld_q[1]);
        issue      = (state_q == READ) && (creditUsed < used_t'(FIFO_DEPTH));
        lastIssue  = issue && (tx_q == TXW'(TILE_W - 1)) && (ty_q == TYW'(TILE_H - 1));

        push       = vld_q[1];
        pop        = (count_q != '0) && pix_ready;
        count_d    = count_q + CNTW'(push) - CNTW'(pop);

        pushRow    = 20'(yOff_q) + 20'(tyPipe1_q);
        pushAddr   = pushRow * 20'(SCREEN_W) + 20'(xOff_q) + 20'(txPipe1_q);
        pushColor  = (tile_bram_read_data[15:0] == 16'hFFFF) ? BG_COLOR
                                                             : tile_bram_read_data[31:16];
        pushLast   = (txPipe1_q == TXW'(TILE_W - 1)) && (tyPipe1_q == TYW'(TILE_H - 1));
        pushBeat   = {pushAddr, pushColor, pushLast};
    end

    // Flush sequencer. It walks the raster one read at a time and shifts the
    // position of each issued read along with the BRAM latency. It raises
    // done once the pipeline and the FIFO are both empty.
    // tile_bram_read_addr always shows the next read to be issued, so during
    // a credit stall it rests on the first address not yet read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            xOff_q    <= '0;
            yOff_q    <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            rdAddr_q  <= '0;
            vld_q     <= '0;
            txPipe0_q <= '0;
            txPipe1_q <= '0;
            tyPipe0_q <= '0;
            tyPipe1_q <= '0;
        end else begin
            vld_q     <= {vld_q[0], issue};
            txPipe1_q <= txPipe0_q;
            tyPipe1_q <= tyPipe0_q;

            if (issue) begin
                txPipe0_q <= tx_q;
                tyPipe0_q <= ty_q;
                // The final position is held rather than stepped past the tile.
                if (!lastIssue) begin
                    rdAddr_q <= rdAddr_q + 10'd1;
                    if (tx_q == TXW'(TILE_W - 1)) begin
                        tx_q <= '0;
                        ty_q <= ty_q + TYW'(1);
                    end else begin
                        tx_q <= tx_q + TXW'(1);
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        xOff_q   <= x_offset;
                        yOff_q   <= y_offset;
                        tx_q     <= '0;
                        ty_q     <= '0;
                        rdAddr_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    if (lastIssue) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((vld_q == 2'b00) && (count_q == '0)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output FIFO. Push and pop may happen in the same cycle. The head entry
    // only changes on a pop, so the outputs hold steady while the downstream
    // stalls. The storage is reset so that every output reads zero after
    // reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= pushBeat;
                wrPtr_q            <= wrPtr_q + PTRW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTRW'(1);
            end
            count_q <= count_d;
        end
    end

    assign headBeat            = fifoMem_q[rdPtr_q];
    assign pix_valid           = (count_q != '0);
    assign pix_addr            = headBeat.addr;
    assign pix_color           = headBeat.color;
    assign pix_last            = headBeat.last;
    assign tile_bram_read_addr = rdAddr_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule
